// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the ring NoC demo front end.
// Holds header field layout, injection FSM states, output FIFO depth and
// the hex-digit to active-low seven-segment encoder.
`timescale 1ns/1ps
package noc_pkg;

  // Header word layout: dest in the low bits, payload length in [7:4]
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_LEN_LSB  = 4;
  localparam int HDR_LEN_W    = 4;

  // Output FIFO depth in words
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WAIT,
    SEND
  } inj_state_t;

  // Active-low segments, bit0 = a ... bit6 = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/noc_debounce.sv
// noc_debounce: 2-flop synchroniser, stable-high counter and rising-edge
// detector; emits a one-cycle press pulse 2 + DEBOUNCE_COUNT + 1 cycles
// after the button rises.
`timescale 1ns/1ps
module noc_debounce #(
  parameter int DEBOUNCE_COUNT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int CW = (DEBOUNCE_COUNT > 0) ? $clog2(DEBOUNCE_COUNT + 1) : 1;

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          level_prev_reg;

  // Synchronise, count consecutive high cycles, and register the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg       <= '0;
      cnt_reg        <= '0;
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], button};
      if (!sync_reg[1]) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CW'(DEBOUNCE_COUNT)) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      level_reg      <= sync_reg[1] && (cnt_reg == CW'(DEBOUNCE_COUNT));
      level_prev_reg <= level_reg;
    end
  end

  assign press = level_reg & ~level_prev_reg;

endmodule

// File: rtl/noc_top.sv
// noc_top: button-driven packet injector feeding a NET_ADDR-stage ring,
// ejecting into a 16-word FWFT FIFO popped onto DataOut.
// Optional feature macro: NOC_HEX_DISPLAY_EN (status on HEX0..HEX5;
// otherwise all digits are blank).
`timescale 1ns/1ps
module noc_top
  import noc_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_PACKET_LEN = 8,
  parameter int NET_ADDR       = 4
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [DATA_WIDTH-1:0] Switches,
  input  logic [1:0]            Buttons,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1,
  output logic [6:0]            HEX2,
  output logic [6:0]            HEX3,
  output logic [6:0]            HEX4,
  output logic [6:0]            HEX5
);

  localparam int DEST_W = $clog2(NET_ADDR);
  localparam int IDX_W  = (MAX_PACKET_LEN > 1) ? $clog2(MAX_PACKET_LEN) : 1;
  localparam int CNT_W  = $clog2(MAX_PACKET_LEN + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0] press;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      noc_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_debounce (
        .clk   (Clock),
        .rst_n (nReset),
        .button(Buttons[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  // Header length field, clamped so the packet fits the capture buffer
  logic [HDR_LEN_W-1:0] len_field;
  logic [IDX_W-1:0]     len_clamped;
  assign len_field = Switches[HDR_LEN_LSB +: HDR_LEN_W];

  // Clamp the requested payload length to MAX_PACKET_LEN-1
  always_comb begin
    if (int'(len_field) > MAX_PACKET_LEN - 1) len_clamped = IDX_W'(MAX_PACKET_LEN - 1);
    else                                       len_clamped = IDX_W'(len_field);
  end

  inj_state_t          state_reg;
  logic [CNT_W-1:0]    wcnt_reg;
  logic [IDX_W-1:0]    plen_reg;
  logic [IDX_W-1:0]    sidx_reg;
  logic [DEST_W-1:0]   dest_reg;
  logic [FCNT_W-1:0]   fifo_count_reg;
  logic [NET_ADDR-1:0] ring_valid;
  logic                ring_empty;
  logic                space_ok;

  // Only one packet is in the ring at a time, so at most one stage ejects per cycle
  assign ring_empty = ~|ring_valid;
  assign space_ok   = ring_empty &&
                      (int'(fifo_count_reg) + int'(plen_reg) + 1 <= FIFO_DEPTH);

  // Injection FSM: capture header and payload, reserve FIFO space, then stream
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
      plen_reg  <= '0;
      sidx_reg  <= '0;
      dest_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (press[0]) begin
          wcnt_reg  <= CNT_W'(1);
          plen_reg  <= len_clamped;
          dest_reg  <= Switches[HDR_DEST_LSB +: DEST_W];
          state_reg <= (len_clamped == '0) ? WAIT : CAPTURE;
        end
        CAPTURE: if (press[0]) begin
          wcnt_reg <= wcnt_reg + CNT_W'(1);
          if (wcnt_reg == CNT_W'(plen_reg)) state_reg <= WAIT;
        end
        WAIT: if (space_ok) begin
          state_reg <= SEND;
          sidx_reg  <= '0;
        end
        SEND: begin
          sidx_reg <= sidx_reg + IDX_W'(1);
          if (sidx_reg == plen_reg) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] pkt_mem [MAX_PACKET_LEN];

  // Packet capture buffer: header at slot 0, payload words follow
  always_ff @(posedge Clock) begin
    if (state_reg == IDLE && press[0]) pkt_mem[0] <= Switches;
    else if (state_reg == CAPTURE && press[0]) pkt_mem[wcnt_reg[IDX_W-1:0]] <= Switches;
  end

  logic [DEST_W-1:0]     ring_tag  [NET_ADDR];
  logic [DATA_WIDTH-1:0] ring_data [NET_ADDR];
  logic [NET_ADDR-1:0]   eject;

  generate
    for (gi = 0; gi < NET_ADDR; gi++) begin : g_eject
      assign eject[gi] = ring_valid[gi] && (ring_tag[gi] == DEST_W'(gi));
    end
  endgenerate

  // Ring pipeline: stage 0 is loaded by SEND; a word leaves at the stage matching its tag
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ring_valid <= '0;
      for (int i = 0; i < NET_ADDR; i++) begin
        ring_tag[i]  <= '0;
        ring_data[i] <= '0;
      end
    end else begin
      ring_valid[0] <= (state_reg == SEND);
      ring_tag[0]   <= dest_reg;
      ring_data[0]  <= pkt_mem[sidx_reg];
      for (int i = 1; i < NET_ADDR; i++) begin
        ring_valid[i] <= ring_valid[i-1] && !eject[i-1];
        ring_tag[i]   <= ring_tag[i-1];
        ring_data[i]  <= ring_data[i-1];
      end
    end
  end

  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;

  // Select the ejecting stage's word for the FIFO write port
  always_comb begin
    push      = |eject;
    push_data = '0;
    for (int i = 0; i < NET_ADDR; i++) begin
      if (eject[i]) push_data = ring_data[i];
    end
  end

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_reg;
  logic [PTR_W-1:0]      rptr_reg;
  logic                  pop;

  assign pop = press[1] && (fifo_count_reg != '0);

  // FIFO storage write port
  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wptr_reg] <= push_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + PTR_W'(1);
      if (pop)  rptr_reg <= rptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + FCNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - FCNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Registered pop output: head word and one-cycle valid strobe
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
    end else begin
      DataValid <= pop;
      if (pop) DataOut <= fifo_mem[rptr_reg];
    end
  end

`ifdef NOC_HEX_DISPLAY_EN
  logic [3:0] fifo_digit;
  assign fifo_digit = (fifo_count_reg > FCNT_W'(15)) ? 4'hF : fifo_count_reg[3:0];
  assign HEX0 = hex_to_seg(DataOut[3:0]);
  assign HEX1 = hex_to_seg(DataOut[7:4]);
  assign HEX2 = hex_to_seg(DataOut[11:8]);
  assign HEX3 = hex_to_seg(DataOut[15:12]);
  assign HEX4 = hex_to_seg(4'(wcnt_reg));
  assign HEX5 = hex_to_seg(fifo_digit);
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
`endif

endmodule

// File: tb/tb_noc_top.sv
// tb_noc_top: directed self-checking bench for noc_top (DEBOUNCE_COUNT = 0).
// Digit expectations follow NOC_HEX_DISPLAY_EN (blank when undefined).
`timescale 1ns/1ps
module tb_noc_top;

  logic        Clock;
  logic        nReset;
  logic [31:0] Switches;
  logic [1:0]  Buttons;
  logic [31:0] DataOut;
  logic        DataValid;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef NOC_HEX_DISPLAY_EN
  localparam logic [6:0] X_0 = 7'h40;
  localparam logic [6:0] X_1 = 7'h79;
  localparam logic [6:0] X_2 = 7'h24;
  localparam logic [6:0] X_A = 7'h08;
  localparam logic [6:0] X_B = 7'h03;
  localparam logic [6:0] X_F = 7'h0E;
`else
  localparam logic [6:0] X_0 = 7'h7F;
  localparam logic [6:0] X_1 = 7'h7F;
  localparam logic [6:0] X_2 = 7'h7F;
  localparam logic [6:0] X_A = 7'h7F;
  localparam logic [6:0] X_B = 7'h7F;
  localparam logic [6:0] X_F = 7'h7F;
`endif

  noc_top #(
    .DEBOUNCE_COUNT(0),
    .DATA_WIDTH    (32),
    .MAX_PACKET_LEN(8),
    .NET_ADDR      (4)
  ) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .Switches (Switches),
    .Buttons  (Buttons),
    .DataOut  (DataOut),
    .DataValid(DataValid),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // One Buttons[0] press with Switches held across the press pulse
  task automatic inject(input logic [31:0] word);
    @(negedge Clock);
    Switches   = word;
    Buttons[0] = 1'b1;
    idle(5);
    Buttons[0] = 1'b0;
    idle(4);
  endtask

  // One Buttons[1] press expecting a DataValid strobe carrying exp
  task automatic pop_expect(input string tag, input logic [31:0] exp, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    @(negedge Clock);
    Buttons[1] = 1'b1;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge Clock);
      if (DataValid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_data"}, DataOut, exp);
    @(negedge Clock);
    check({tag, "_strobe_len"}, 32'(DataValid), 32'd0);
    Buttons[1] = 1'b0;
    idle(4);
  endtask

  // One Buttons[1] press expecting no strobe and DataOut holding hold_val
  task automatic pop_none(input string tag, input logic [31:0] hold_val);
    bit seen;
    seen = 1'b0;
    @(negedge Clock);
    Buttons[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (DataValid) seen = 1'b1;
    end
    check({tag, "_novalid"}, 32'(seen), 32'd0);
    check({tag, "_hold"}, DataOut, hold_val);
    Buttons[1] = 1'b0;
    idle(4);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] fill_words [16];
  int          lat;

  initial begin
    nReset   = 1'b0;
    Switches = '0;
    Buttons  = '0;
    idle(3);
    nReset = 1'b1;
    idle(1);

    // Reset state
    check("rst_dataout", DataOut, 32'h0);
    check("rst_valid", 32'(DataValid), 32'h0);
    check("rst_hex0", 32'(HEX0), 32'(X_0));
    check("rst_hex4", 32'(HEX4), 32'(X_0));
    check("rst_hex5", 32'(HEX5), 32'(X_0));
    pop_none("rst_pop_empty", 32'h0);

    // Header 0x10: dest 0, L = 1 -> CAPTURE with wcnt = 1, FIFO still empty
    inject(32'h10);
    check("cap_hex4", 32'(HEX4), 32'(X_1));
    pop_none("cap_pop_empty", 32'h0);

    // Payload 8 completes the packet; dest 0 words land one cycle after stage 0
    inject(32'h8);
    idle(10);
    pop_expect("p1_w0", 32'h10, lat);
    check("pop_latency", 32'(lat), 32'd4);
    pop_expect("p1_w1", 32'h8, lat);
    check("p1_hex4_idle", 32'(HEX4), 32'(X_0));
    pop_none("p1_drained", 32'h8);

    // Header 0x23: dest 3, L = 2
    inject(32'h23);
    inject(32'h9);
    inject(32'hA);
    idle(10);
    pop_expect("p2_w0", 32'h23, lat);
    pop_expect("p2_w1", 32'h9, lat);
    pop_expect("p2_w2", 32'hA, lat);

    // Header 0x00: single-word packet, sent straight from the header press
    inject(32'h0);
    idle(10);
    pop_expect("p3_w0", 32'h0, lat);
    check("p3_hex0", 32'(HEX0), 32'(X_0));
    pop_none("p3_drained", 32'h0);

    // Fill 15 words: 0x70 (L=7) + 7 payloads, 0x61 (L=6) + 6 payloads
    fill_words[0] = 32'h70;
    for (int i = 1; i <= 7; i++) fill_words[i] = 32'(i);
    fill_words[8] = 32'h61;
    for (int i = 9; i <= 14; i++) fill_words[i] = 32'h11 + 32'(i - 9);
    fill_words[15] = 32'h12;
    for (int i = 0; i < 15; i++) begin
      inject(fill_words[i]);
      if (i == 7) idle(10);
    end
    idle(10);

    // Header 0x12 (dest 2, L = 1) needs 2 free slots but only 1 is free
    inject(32'h12);
    inject(32'hAB);
    idle(20);
    check("wait_hex4", 32'(HEX4), 32'(X_2));
    check("wait_hex5_15", 32'(HEX5), 32'(X_F));

    // One pop frees a second slot; the held packet goes out, count reaches 16
    pop_expect("fill_w0", 32'h70, lat);
    idle(20);
    check("sent_hex4", 32'(HEX4), 32'(X_0));
    check("sent_hex5_sat", 32'(HEX5), 32'(X_F));

    for (int i = 1; i < 16; i++) begin
      pop_expect($sformatf("fill_w%0d", i), fill_words[i], lat);
    end
    pop_expect("fill_w16", 32'hAB, lat);
    check("drain_hex0", 32'(HEX0), 32'(X_B));
    check("drain_hex1", 32'(HEX1), 32'(X_A));
    check("drain_hex5", 32'(HEX5), 32'(X_0));
    pop_none("final_empty", 32'hAB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noc_top.md
# noc_top

Demo-board network-on-chip front end: debounced push-buttons inject words from the slide switches as packets into a NET_ADDR-stage pipelined ring. Words are ejected at the destination stage into an output FIFO, then popped one per button press onto DataOut. Six seven-segment digits show status. Sits directly under the FPGA top level, between board I/O and the parallel-computer fabric.

## Interface
- DEBOUNCE_COUNT, default 50000: cycles a synchronised button must be stable high before it counts as pressed; 0 means accept on first synchronised high.
- DATA_WIDTH, default 32: word width.
- MAX_PACKET_LEN, default 8: maximum packet words, header included.
- NET_ADDR, default 4: number of ring stages/nodes; power of two ≥ 2.
- Clock  in  1  single system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Switches  in  DATA_WIDTH  word to inject.
- Buttons  in  2  [0] inject the Switches word; [1] pop one output word. Active high, asynchronous.
- DataOut  out  DATA_WIDTH  last popped word.
- DataValid  out  1  one-cycle strobe when DataOut updates.
- HEX0..HEX5  out  7 each  seven-segment digits, active-low, bit0 = a … bit6 = g.

## Operation
- Each button passes through a 2-flop synchroniser, then a debounce counter, then a rising-edge detector, giving a single press pulse.
- Header word format:
  - dest = bits[$clog2(NET_ADDR)-1:0].
  - L = bits[7:4], the payload length, clamped to MAX_PACKET_LEN-1.
  - All other bits are ignored but carried.
- Injection FSM states:
  - IDLE → CAPTURE on the first Buttons[0] press. Store the header and set wcnt = 1. If L = 0, go to WAIT instead.
  - CAPTURE: each Buttons[0] press stores Switches and increments wcnt. When wcnt = L+1, go to WAIT.
  - WAIT: when output FIFO free space ≥ L+1, go to SEND.
  - SEND: stream one word per cycle into ring stage 0, tagged with dest. After the last word, go to IDLE and clear wcnt.
  - Buttons[0] presses in WAIT or SEND are dropped.
- Ring: NET_ADDR register stages. A word in stage i with tag i is written into the output FIFO and removed; otherwise it advances to stage i+1. The ring never stalls, because space is reserved before SEND.
- Output FIFO: 16 words, first-word-fall-through.
- Buttons[1] press with FIFO non-empty: DataOut ← head word, DataValid = 1 for one cycle, pop.
- Buttons[1] press with FIFO empty: ignored; DataOut holds and DataValid stays 0.
- FIFO push and pop in the same cycle are both honoured.
- Simultaneous presses on both buttons are both processed.

## Timing
- Reset values: DataOut = 0, DataValid = 0, FSM in IDLE, wcnt = 0, FIFO empty, ring empty.
- HEX reset values: HEX0–HEX3 and HEX5 show 0, HEX4 shows 0.
- Press pulse occurs 2 + DEBOUNCE_COUNT + 1 cycles after a button rises (3 cycles when DEBOUNCE_COUNT = 0).
- Switches is sampled in the press-pulse cycle.
- SEND starts on the cycle after entering WAIT, if space is available.
- Word k enters stage 0 at SEND cycle k and is in the FIFO dest+1 cycles later.
- Pop: DataOut and DataValid are registered and update on the cycle after the press pulse.
- Reset asserted mid-packet discards all buffered words.

## Configuration
- NOC_HEX_DISPLAY_EN defined:
  - HEX0–HEX3 show DataOut[15:0] as hex.
  - HEX4 shows wcnt.
  - HEX5 shows FIFO count, saturating at F.
- NOC_HEX_DISPLAY_EN undefined: all HEX outputs are 7'h7F (blank) and the decoders are absent.

## Structure
- Package noc_pkg holds:
  - The header field positions and widths.
  - The FSM state enum {IDLE, CAPTURE, WAIT, SEND}.
  - The FIFO depth constant (16).
  - The hex-to-seven-segment function.
- One sub-module, noc_debounce (synchroniser + counter + edge detect), instantiated once per button.

## Test plan
- Reset, DEBOUNCE_COUNT = 0 → DataOut = 0, DataValid = 0, HEX4 = "0", HEX5 = "0".
- Switches = 16, press Buttons[0] → wcnt = 1 (HEX4 = "1"), FSM in CAPTURE; FIFO stays empty; a Buttons[1] press gives no DataValid.
- Header 16, then press with payload 8 → FIFO receives 0x10 and 0x08 within 3 cycles. Two Buttons[1] presses give DataValid pulses with DataOut = 0x10, then 0x08.
- Header 0x23 (dest 3, L = 2), payloads 9 and 10 → each word arrives 4 cycles after injection; pops return 0x23, 9, 10.
- Header 0x00 (L = 0) → single-word packet delivered immediately after the press; one pop returns 0.
- Fill the FIFO to 15 words, then send a packet with L = 1 → FSM holds in WAIT. After one pop, the packet is sent and HEX5 shows "F" (count 16, saturated).
